// File: rtl/mdv_issue_queue_pkg.sv
// Shared types for the MDV issue queue: op codes, request bundle, depth.
// Helper predicates classify ops by how they drive the MDV unit.
package mdv_issue_queue_pkg;

    localparam int MDV_ISSUE_DEPTH = 4;
    localparam int MDV_TAG_W       = 5;

    typedef enum logic [3:0] {
        MDV_none  = 4'd0,
        MDV_mult  = 4'd1,
        MDV_multu = 4'd2,
        MDV_div   = 4'd3,
        MDV_divu  = 4'd4,
        MDV_mthi  = 4'd5,
        MDV_mtlo  = 4'd6,
        MDV_mfhi  = 4'd7,
        MDV_mflo  = 4'd8
    } MDVOPTION;

    typedef struct packed {
        MDVOPTION              op;
        logic [31:0]           a;
        logic [31:0]           b;
        logic [MDV_TAG_W-1:0]  tag;
    } mdv_req_t;

    function automatic logic op_start(MDVOPTION op);
        return op inside {MDV_mult, MDV_multu, MDV_div, MDV_divu};
    endfunction

    function automatic logic op_mt(MDVOPTION op);
        return op inside {MDV_mthi, MDV_mtlo};
    endfunction

    function automatic logic op_mf(MDVOPTION op);
        return op inside {MDV_mfhi, MDV_mflo};
    endfunction

    function automatic logic op_mdv(MDVOPTION op);
        return op_start(op) || op_mt(op) || op_mf(op);
    endfunction

endpackage

// File: rtl/mdv_issue_queue_if.sv
// Upstream request, MDV unit and result signals of the issue queue.
// master = environment side, slave = the queue itself.
interface mdv_issue_queue_if
    import mdv_issue_queue_pkg::*;
#(
    parameter int TAG_W = MDV_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    MDVOPTION         in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             mdv_busy;
    logic [31:0]      mdv_ans;
    logic             mdv_start;
    MDVOPTION         mdv_op;
    logic [31:0]      mdv_a;
    logic [31:0]      mdv_b;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;
    logic             empty;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output mdv_busy, mdv_ans,
        input  in_ready, mdv_start, mdv_op, mdv_a, mdv_b,
        input  res_valid, res_tag, res_data, empty
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  mdv_busy, mdv_ans,
        output in_ready, mdv_start, mdv_op, mdv_a, mdv_b,
        output res_valid, res_tag, res_data, empty
    );
endinterface

// File: rtl/mdv_req_fifo.sv
// In-order request store: DEPTH entries, one push and one pop per cycle.
// DEPTH is a power of two so the pointers wrap by natural overflow.
module mdv_req_fifo
    import mdv_issue_queue_pkg::*;
#(
    parameter int DEPTH = MDV_ISSUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  mdv_req_t                   wdata,
    output mdv_req_t                   rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    mdv_req_t        mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     inc;
    logic [AW:0]     dec;

    assign inc   = {{AW{1'b0}}, push};
    assign dec   = {{AW{1'b0}}, pop};
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + inc - dec;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mdv_issue_queue.sv
// Buffers mult/div/mt/mf ops and issues them to MDV in order,
// returning mfhi/mflo values tagged with their destination register.
module mdv_issue_queue
    import mdv_issue_queue_pkg::*;
#(
    parameter int DEPTH = MDV_ISSUE_DEPTH,
    parameter int TAG_W = MDV_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    mdv_issue_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    mdv_req_t      head;
    mdv_req_t      wreq;
    logic          push;
    logic          issue_ok;
    logic          guard;
    logic          head_mf;

    assign bus.in_ready = count < CW'(DEPTH);
    assign push         = bus.in_valid && bus.in_ready;

    assign wreq.op  = bus.in_op;
    assign wreq.a   = bus.in_a;
    assign wreq.b   = bus.in_b;
    assign wreq.tag = MDV_TAG_W'(bus.in_tag);

    // Held off during reset so MDV never sees a half-flushed head.
    assign issue_ok = !reset && (count != '0)
                    && !bus.mdv_busy && !guard;
    assign head_mf  = op_mf(head.op);
    assign bus.empty = (count == '0) && !guard;

    mdv_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (issue_ok),
        .wdata (wreq),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        bus.mdv_start = 1'b0;
        bus.mdv_op    = MDV_none;
        bus.mdv_a     = '0;
        bus.mdv_b     = '0;
        if (issue_ok) begin
            unique case (1'b1)
                op_start(head.op): begin
                    bus.mdv_start = 1'b1;
                    bus.mdv_op    = head.op;
                    bus.mdv_a     = head.a;
                    bus.mdv_b     = head.b;
                end
                op_mt(head.op): begin
                    bus.mdv_op = head.op;
                    bus.mdv_a  = head.a;
                end
                op_mf(head.op): begin
                    bus.mdv_op = head.op;
                end
                default: ;
            endcase
        end
    end

    // Guard spans the busy rise after start and the hi/lo write of mt.
    always_ff @(posedge clk) begin
        if (reset) begin
            guard         <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_tag   <= '0;
            bus.res_data  <= '0;
        end else begin
            guard         <= issue_ok && op_mdv(head.op);
            bus.res_valid <= issue_ok && head_mf;
            if (issue_ok && head_mf) begin
                bus.res_tag  <= TAG_W'(head.tag);
                bus.res_data <= bus.mdv_ans;
            end
        end
    end
endmodule

// File: tb/tb_mdv_issue_queue.sv
// Directed and random stimulus for mdv_issue_queue against a program-order
// queue model; a small MDV stub supplies busy timing and hi/lo storage.
module tb_mdv_issue_queue;
    import mdv_issue_queue_pkg::*;

    logic clk;
    logic reset;
    logic hold_busy;
    int   checks;
    int   failures;
    int   starts;
    int   cyc;

    mdv_issue_queue_if bus ();

    mdv_issue_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] smul(logic [31:0] a, logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    function automatic logic [63:0] umul(logic [31:0] a, logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // {remainder, quotient}
    function automatic logic [63:0] sdiv(logic [31:0] a, logic [31:0] b);
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] q;
        logic signed [31:0] r;
        x = a;
        y = b;
        q = x / y;
        r = x % y;
        return {r, q};
    endfunction

    function automatic logic [63:0] udiv(logic [31:0] a, logic [31:0] b);
        return {a % b, a / b};
    endfunction

    // MDV stub: busy 5 cycles after a mult start, 10 after a div start.
    logic [31:0] hi;
    logic [31:0] lo;
    int          bcnt;

    assign bus.mdv_busy = (bcnt != 0) || hold_busy;
    assign bus.mdv_ans  = (bus.mdv_op == MDV_mfhi) ? hi : lo;

    always @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            bcnt <= 0;
        end else begin
            if (bcnt != 0) bcnt <= bcnt - 1;
            if (bus.mdv_start) begin
                starts <= starts + 1;
                case (bus.mdv_op)
                    MDV_mult:  {hi, lo} <= smul(bus.mdv_a, bus.mdv_b);
                    MDV_multu: {hi, lo} <= umul(bus.mdv_a, bus.mdv_b);
                    MDV_div:   {hi, lo} <= sdiv(bus.mdv_a, bus.mdv_b);
                    MDV_divu:  {hi, lo} <= udiv(bus.mdv_a, bus.mdv_b);
                    default: ;
                endcase
                if (bus.mdv_op inside {MDV_div, MDV_divu}) bcnt <= 10;
                else bcnt <= 5;
            end
            if (bus.mdv_op == MDV_mthi) hi <= bus.mdv_a;
            if (bus.mdv_op == MDV_mtlo) lo <= bus.mdv_a;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural hi/lo evaluated in program order at
    // push time; entries leave one per cycle when MDV is free and no
    // MDV op left the previous cycle.
    typedef struct {
        MDVOPTION    op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;
    logic        guard_m;
    logic        res_pend;
    logic [4:0]  res_tag_e;
    logic [31:0] res_data_e;

    function automatic logic is_start(MDVOPTION op);
        return op == MDV_mult || op == MDV_multu
            || op == MDV_div  || op == MDV_divu;
    endfunction

    function automatic logic is_real(MDVOPTION op);
        return is_start(op) || op == MDV_mthi || op == MDV_mtlo
            || op == MDV_mfhi || op == MDV_mflo;
    endfunction

    task automatic model_push();
        ent_t e;
        e.op  = bus.in_op;
        e.a   = bus.in_a;
        e.b   = bus.in_b;
        e.tag = bus.in_tag;
        e.res = '0;
        case (e.op)
            MDV_mult:  {ref_hi, ref_lo} = smul(e.a, e.b);
            MDV_multu: {ref_hi, ref_lo} = umul(e.a, e.b);
            MDV_div:   {ref_hi, ref_lo} = sdiv(e.a, e.b);
            MDV_divu:  {ref_hi, ref_lo} = udiv(e.a, e.b);
            MDV_mthi:  ref_hi = e.a;
            MDV_mtlo:  ref_lo = e.a;
            MDV_mfhi:  e.res = ref_hi;
            MDV_mflo:  e.res = ref_lo;
            default: ;
        endcase
        mq.push_back(e);
    endtask

    task automatic step();
        int   sz;
        logic ei;
        ent_t h;
        cyc++;
        if (res_pend) begin
            chk("res_valid", bus.res_valid, 1);
            chk("res_tag", bus.res_tag, res_tag_e);
            chk("res_data", bus.res_data, res_data_e);
        end else begin
            chk("res_quiet", bus.res_valid, 0);
        end
        res_pend = 1'b0;
        sz = mq.size();
        chk("in_ready", bus.in_ready, sz < 4);
        chk("empty", bus.empty, sz == 0 && !guard_m);
        ei = !reset && sz > 0 && !bus.mdv_busy && !guard_m;
        guard_m = 1'b0;
        if (ei) begin
            h = mq.pop_front();
            if (is_real(h.op)) begin
                guard_m = 1'b1;
                chk("issue_op", bus.mdv_op, h.op);
                chk("issue_start", bus.mdv_start, is_start(h.op));
                if (is_start(h.op) || h.op == MDV_mthi
                    || h.op == MDV_mtlo)
                    chk("issue_a", bus.mdv_a, h.a);
                if (is_start(h.op)) chk("issue_b", bus.mdv_b, h.b);
                if (h.op == MDV_mfhi || h.op == MDV_mflo) begin
                    res_pend   = 1'b1;
                    res_tag_e  = h.tag;
                    res_data_e = h.res;
                end
            end else begin
                chk("skip_op", bus.mdv_op, MDV_none);
                chk("skip_start", bus.mdv_start, 0);
            end
        end else begin
            chk("idle_op", bus.mdv_op, MDV_none);
            chk("idle_start", bus.mdv_start, 0);
            chk("idle_a", bus.mdv_a, 0);
            chk("idle_b", bus.mdv_b, 0);
        end
        if (reset) begin
            mq.delete();
            guard_m  = 1'b0;
            res_pend = 1'b0;
            ref_hi   = '0;
            ref_lo   = '0;
        end else if (bus.in_valid && sz < 4) begin
            model_push();
        end
    endtask

    initial forever begin
        @(negedge clk);
        step();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_accept();
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 200) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push(MDVOPTION op, logic [31:0] a,
                        logic [31:0] b, logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        wait_accept();
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_res(logic [4:0] tag, logic [31:0] data);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.res_valid) break;
            n++;
        end
        chk("res_seen", n < 100, 1);
        chk("res_tag_dir", bus.res_tag, tag);
        chk("res_data_dir", bus.res_data, data);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 300 && !(mq.size() == 0 && bus.empty
                            && !bus.mdv_busy)) begin
            @(negedge clk);
            n++;
        end
        chk("drain", n < 300, 1);
        idle(3);
    endtask

    initial begin
        int          s0;
        logic [31:0] ra;
        logic [31:0] rb;
        checks       = 0;
        failures     = 0;
        starts       = 0;
        cyc          = 0;
        ref_hi       = '0;
        ref_lo       = '0;
        guard_m      = 1'b0;
        res_pend     = 1'b0;
        res_tag_e    = '0;
        res_data_e   = '0;
        reset        = 1'b1;
        hold_busy    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = MDV_none;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_res_tag", bus.res_tag, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_empty", bus.empty, 1);
        @(posedge clk);
        #1;

        // mult 3 * -4, then mflo
        s0 = starts;
        push(MDV_mult, 32'd3, 32'hFFFFFFFC, 5'd0);
        push(MDV_mflo, 32'd0, 32'd0, 5'd8);
        idle(0);
        wait_res(5'd8, 32'hFFFFFFF4);
        chk("mult_starts", starts - s0, 1);
        drain();

        // mtlo then mflo back-to-back
        push(MDV_mtlo, 32'h1234, 32'd0, 5'd0);
        push(MDV_mflo, 32'd0, 32'd0, 5'd2);
        idle(0);
        wait_res(5'd2, 32'h1234);
        drain();

        // divu 100/7 with in_valid held across mfhi/mflo
        push(MDV_divu, 32'd100, 32'd7, 5'd0);
        push(MDV_mfhi, 32'd0, 32'd0, 5'd1);
        push(MDV_mflo, 32'd0, 32'd0, 5'd2);
        idle(0);
        wait_res(5'd1, 32'd2);
        wait_res(5'd2, 32'd14);
        drain();

        // five ops while MDV is held busy
        hold_busy = 1'b1;
        push(MDV_mthi, 32'hAAAA, 32'd0, 5'd0);
        push(MDV_mtlo, 32'h5555, 32'd0, 5'd0);
        push(MDV_mfhi, 32'd0, 32'd0, 5'd3);
        push(MDV_mflo, 32'd0, 32'd0, 5'd4);
        bus.in_valid = 1'b1;
        bus.in_op    = MDV_multu;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd9;
        bus.in_tag   = 5'd0;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        hold_busy = 1'b0;
        wait_accept();
        idle(0);
        wait_res(5'd3, 32'hAAAA);
        wait_res(5'd4, 32'h5555);
        drain();

        // reset three cycles into a div with two ops queued
        push(MDV_div, 32'hFFFFFF9C, 32'd7, 5'd0);
        push(MDV_mfhi, 32'd0, 32'd0, 5'd5);
        push(MDV_mflo, 32'd0, 32'd0, 5'd6);
        idle(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("flush_ready", bus.in_ready, 1);
        chk("flush_op", bus.mdv_op, MDV_none);
        chk("flush_res", bus.res_valid, 0);
        chk("flush_empty", bus.empty, 1);
        @(posedge clk);
        #1;
        push(MDV_mult, 32'd7, 32'd6, 5'd0);
        push(MDV_mflo, 32'd0, 32'd0, 5'd3);
        idle(0);
        wait_res(5'd3, 32'd42);
        drain();

        // MDV_none and a non-MDV code pass through silently
        push(MDV_none, 32'h1, 32'h2, 5'd0);
        push(MDVOPTION'(4'd12), 32'h3, 32'h4, 5'd0);
        push(MDV_mfhi, 32'd0, 32'd0, 5'd9);
        idle(0);
        wait_res(5'd9, 32'd0);
        drain();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                hold_busy = ($urandom_range(0, 3) == 0);
                idle(1);
            end
            hold_busy = 1'b0;
            ra = $urandom;
            rb = $urandom;
            if (rb == 0) rb = 32'd1;
            push(MDVOPTION'(4'($urandom_range(0, 15))), ra, rb,
                 5'($urandom_range(0, 31)));
        end
        idle(0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
